// File: rtl/rv_mm_port_router_if.sv
// rv_mm_port_router_if
//   Bundles the memory-mapped master bus and the broadcast Avalon-style slave
//   bus around rv_mm_port_router.
//   Modports:
//     slave  - the router: receives master requests, returns acks/read data,
//              drives the slave address/data/strobes, receives per-port
//              read data and waitrequest.
//     master - the environment: the bus master plus the attached slaves.
//   Signals:
//     m_addr/m_write/m_writedata/m_byteenable/m_read  master request
//     m_readdata/m_wrack/m_rdack/m_err                 master response
//     s_address/s_writedata/s_byteenable               broadcast slave bus
//     s_write/s_read                                   per-port strobes
//     s_readdata/s_waitrequest                         per-port responses
interface rv_mm_port_router_if #(
   parameter int unsigned NUM_PORTS = 4
);
   logic [31:0]             m_addr;
   logic                    m_write;
   logic [31:0]             m_writedata;
   logic [3:0]              m_byteenable;
   logic                    m_read;
   logic [31:0]             m_readdata;
   logic                    m_wrack;
   logic                    m_rdack;
   logic                    m_err;
   logic [31:0]             s_address;
   logic [31:0]             s_writedata;
   logic [3:0]              s_byteenable;
   logic [NUM_PORTS-1:0]    s_write;
   logic [NUM_PORTS-1:0]    s_read;
   logic [NUM_PORTS*32-1:0] s_readdata;
   logic [NUM_PORTS-1:0]    s_waitrequest;

   modport slave (
      input  m_addr, m_write, m_writedata, m_byteenable, m_read,
      output m_readdata, m_wrack, m_rdack, m_err,
      output s_address, s_writedata, s_byteenable, s_write, s_read,
      input  s_readdata, s_waitrequest
   );

   modport master (
      output m_addr, m_write, m_writedata, m_byteenable, m_read,
      input  m_readdata, m_wrack, m_rdack, m_err,
      input  s_address, s_writedata, s_byteenable, s_write, s_read,
      output s_readdata, s_waitrequest
   );
endinterface

// File: rtl/rv_mm_port_router.sv
// rv_mm_port_router
//   Decodes each memory-mapped master access against NUM_PORTS base/mask
//   regions (lowest index wins) and forwards it to one Avalon-style slave
//   port. The request is registered and held across s_waitrequest; the
//   master receives a registered one-cycle read/write ack. Unmapped accesses
//   (and, when enabled, hung ones) complete with m_err and DECERR_DATA.
//   Ports:
//     clk     system clock, rising edge
//     nreset  asynchronous active-low reset
//     bus     rv_mm_port_router_if.slave (master request/response and the
//             broadcast slave bus, see interface header)
//   Optional feature: define RV_ROUTER_WDOG_EN to enable the ACCESS
//   watchdog (limit TIMEOUT cycles). Without it ACCESS waits indefinitely.
module rv_mm_port_router #(
   parameter int unsigned               NUM_PORTS   = 4,
   parameter logic [NUM_PORTS*32-1:0]   PORT_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                       32'h8000_0000, 32'h0000_0000},
   parameter logic [NUM_PORTS*32-1:0]   PORT_MASK   = {4{32'hFFFF_0000}},
   parameter bit                        STRIP_ADDR  = 1'b0,
   parameter logic [31:0]               DECERR_DATA = 32'hDEAD_BEEF,
   parameter int unsigned               TIMEOUT     = 1024
) (
   input logic                  clk,
   input logic                  nreset,
   rv_mm_port_router_if.slave   bus
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            wr_q, wr_d;
   logic [PW-1:0]   port_q, port_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

`ifdef RV_ROUTER_WDOG_EN
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WW-1:0]   wdog_q, wdog_d;
`endif

   // Address decode and selected-port response mux
   logic            hit;
   logic [PW-1:0]   hit_idx;
   logic [31:0]     hit_mask;
   logic            sel_wait;
   logic [31:0]     sel_rdata;

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_mask = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!hit && ((bus.m_addr & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32])) begin
            hit      = 1'b1;
            hit_idx  = PW'(i);
            hit_mask = PORT_MASK[32*i +: 32];
         end
      end
      sel_wait  = bus.s_waitrequest[port_q];
      sel_rdata = bus.s_readdata[32*port_q +: 32];
   end

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         wr_q    <= 1'b0;
         port_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef RV_ROUTER_WDOG_EN
         wdog_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         wr_q    <= wr_d;
         port_q  <= port_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
`ifdef RV_ROUTER_WDOG_EN
         wdog_q  <= wdog_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      wr_d    = wr_q;
      port_d  = port_q;
      err_d   = err_q;
      rdata_d = rdata_q;
`ifdef RV_ROUTER_WDOG_EN
      wdog_d  = wdog_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.m_read || bus.m_write) begin
               // hit_mask is zero on a miss, so stripping leaves the address intact
               addr_d  = STRIP_ADDR ? (bus.m_addr & ~hit_mask) : bus.m_addr;
               wdata_d = bus.m_writedata;
               be_d    = bus.m_byteenable;
               wr_d    = bus.m_write;     // write wins over a simultaneous read
               port_d  = hit_idx;
               err_d   = !hit;
               if (hit) begin
                  state_d = ACCESS;
`ifdef RV_ROUTER_WDOG_EN
                  wdog_d  = '0;
`endif
               end else begin
                  state_d = RESP;
                  // m_readdata only moves on a read ack
                  if (!bus.m_write) rdata_d = DECERR_DATA;
               end
            end
         end
         ACCESS: begin
            if (!sel_wait) begin
               // slave completion takes priority over a same-cycle timeout
               state_d = RESP;
               err_d   = 1'b0;
               if (!wr_q) rdata_d = sel_rdata;
            end
`ifdef RV_ROUTER_WDOG_EN
            else if (wdog_q == WW'(TIMEOUT - 1)) begin
               state_d = RESP;
               err_d   = 1'b1;
               if (!wr_q) rdata_d = DECERR_DATA;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         RESP: begin
            // request is not sampled here, so a held request is not replayed
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.s_write = '0;
      bus.s_read  = '0;
      if (state_q == ACCESS) begin
         if (wr_q) bus.s_write[port_q] = 1'b1;
         else      bus.s_read[port_q]  = 1'b1;
      end
      bus.s_address    = addr_q;
      bus.s_writedata  = wdata_q;
      bus.s_byteenable = be_q;
      bus.m_wrack      = (state_q == RESP) &&  wr_q;
      bus.m_rdack      = (state_q == RESP) && !wr_q;
      bus.m_err        = (state_q == RESP) &&  err_q;
      bus.m_readdata   = rdata_q;
   end

endmodule
